// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake, word type and the memory-arbiter state/owner encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISERVE = 2'd1,
        DSERVE = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int ARB_TIMEOUT_DEFAULT = 1023;

    // True when the RAM has finished the current access, successfully or not.
    function automatic logic ramDone(ramstate_t s);
        return (s == ACCESS) || (s == ERROR);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog for mem_arbiter: loadable up-counter with clear and a
// terminal flag that rises as the count reaches TIMEOUT.
module mem_arb_watchdog
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             inc,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    // Flag the increment that lands on LIMIT so a serve state lasts exactly TIMEOUT cycles.
    assign terminal = (count == LIMIT) || (inc && (count == (LIMIT - 1'b1)));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the shared RAM port between instruction fetch (I) and MEM-stage data (D).
// Optional I-side fairness limit is built when MEM_ARB_FAIR_EN is defined.
//
// state  | meaning
// IDLE   | no transaction; picks D (or I) and latches its request
// ISERVE | RAM read strobe held for the latched instruction address
// DSERVE | RAM read or write strobe held for the latched data request
// DONE   | one-cycle completion; owner's wait drops
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
`ifdef MEM_ARB_FAIR_EN
    ,
    parameter int DSTREAK_MAX = 4
`endif
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_t state, stateNext;
    arb_owner_t owner;
    ramstate_t  ramState;

    word_t addrLat;
    word_t storeLat;
    logic  writeLat;
    word_t iloadReg;
    word_t dloadReg;
    logic  memerrReg;

    logic dReq;
    logic pickD;
    logic grantD;
    logic grantI;
    logic finishOk;
    logic finishErr;
    logic serving;
    logic wdInc;
    logic wdTerminal;

    assign ramState = ramstate_t'(ramstate);
    assign dReq     = dREN | dWEN;
    assign serving  = (state == ISERVE) || (state == DSERVE);
    assign wdInc    = serving && !ramDone(ramState);

`ifdef MEM_ARB_FAIR_EN
    localparam int STREAK_W = $clog2(DSTREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DSTREAK_MAX);

    logic [STREAK_W-1:0] streak;

    // Only D grants that overtook a waiting I count toward the streak.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak <= '0;
        end else if (grantI) begin
            streak <= '0;
        end else if (grantD) begin
            streak <= iREN ? streak + 1'b1 : '0;
        end
    end

    assign pickD = dReq && !(iREN && (streak == STREAK_LIMIT));
`else
    assign pickD = dReq;
`endif

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (WD_W)
    ) u_watchdog (
        .CLK      (CLK),
        .nRST     (nRST),
        .clr      (grantD | grantI),
        .load     (1'b0),
        .loadVal  ({WD_W{1'b0}}),
        .inc      (wdInc),
        .terminal (wdTerminal)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        grantD    = 1'b0;
        grantI    = 1'b0;
        finishOk  = 1'b0;
        finishErr = 1'b0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        case (state)
            IDLE: begin
                if (pickD) begin
                    grantD    = 1'b1;
                    stateNext = DSERVE;
                end else if (iREN) begin
                    grantI    = 1'b1;
                    stateNext = ISERVE;
                end
            end
            ISERVE, DSERVE: begin
                if (state == ISERVE) begin
                    ramREN = 1'b1;
                end else begin
                    ramWEN = writeLat;
                    ramREN = !writeLat;
                end
                // A RAM-reported result wins over a watchdog expiring in the same cycle.
                if (ramState == ACCESS) begin
                    finishOk  = 1'b1;
                    stateNext = DONE;
                end else if ((ramState == ERROR) || wdTerminal) begin
                    finishErr = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Request latches: later changes on the requester side are ignored until the next grant.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            owner    <= OWN_I;
            addrLat  <= '0;
            storeLat <= '0;
            writeLat <= 1'b0;
        end else if (grantD) begin
            owner    <= OWN_D;
            addrLat  <= daddr;
            storeLat <= dstore;
            writeLat <= dWEN;
        end else if (grantI) begin
            owner    <= OWN_I;
            addrLat  <= iaddr;
            writeLat <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iloadReg  <= '0;
            dloadReg  <= '0;
            memerrReg <= 1'b0;
        end else if (finishErr) begin
            memerrReg <= 1'b1;
            if (owner == OWN_D) begin
                dloadReg <= '0;
            end else begin
                iloadReg <= '0;
            end
        end else if (finishOk && !writeLat) begin
            if (owner == OWN_D) begin
                dloadReg <= ramload;
            end else begin
                iloadReg <= ramload;
            end
        end
    end

    assign ramaddr  = addrLat;
    assign ramstore = storeLat;
    assign iload    = iloadReg;
    assign dload    = dloadReg;
    assign memerr   = memerrReg;

    assign iwait = iREN & ~((state == DONE) && (owner == OWN_I));
    assign dwait = dReq & ~((state == DONE) && (owner == OWN_D));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected completions,
// a negedge monitor pops them whenever a requester's wait drops.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic [31:0] iload, dload;
    logic        iwait, dwait;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        memerr;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .TIMEOUT (8)
`ifdef MEM_ARB_FAIR_EN
        ,
        .DSTREAK_MAX (2)
`endif
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .memerr   (memerr)
    );

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    always @(posedge CLK) cyc++;

    // RAM model: BUSY for busyCycles strobe cycles, then ACCESS (or ERROR).
    logic [31:0] ramMem [logic [31:0]];
    int          busyCycles = 0;
    bit          respErr    = 1'b0;
    int          strobeCnt  = 0;
    int          rdCycles   = 0;
    int          wrCycles   = 0;
    logic [31:0] lastAddr   = '0;
    logic [31:0] lastStore  = '0;

    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            if (ramREN) rdCycles++;
            if (ramWEN) wrCycles++;
            lastAddr  = ramaddr;
            lastStore = ramstore;
            ramload   = ramMem.exists(ramaddr) ? ramMem[ramaddr] : 32'h0;
            if (strobeCnt >= busyCycles) begin
                ramstate = respErr ? ERROR : ACCESS;
                if (!respErr && ramWEN) ramMem[ramaddr] = ramstore;
            end else begin
                ramstate = BUSY;
            end
            strobeCnt++;
        end else begin
            strobeCnt = 0;
            ramstate  = FREE;
        end
    end

    typedef struct {
        bit          isD;
        bit          chkData;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t expQ[$];
    int   nCompleted  = 0;
    int   lastDoneCyc = 0;

    task automatic pushExp(input bit isD, input bit chkData, input logic [31:0] data, input bit err);
        exp_t e;
        e.isD = isD; e.chkData = chkData; e.data = data; e.err = err;
        expQ.push_back(e);
    endtask

    task automatic score(input bit isD, input logic [31:0] data);
        exp_t e;
        if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("FAIL unexpected completion: actual %s-side done, required none", isD ? "D" : "I");
        end else begin
            e = expQ.pop_front();
            check("completion owner (1=D)", 32'(isD), 32'(e.isD));
            if (e.chkData) check(isD ? "dload" : "iload", data, e.data);
            check("memerr at completion", 32'(memerr), 32'(e.err));
        end
        nCompleted++;
        lastDoneCyc = cyc;
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if ((dREN || dWEN) && dwait === 1'b0) score(1'b1, dload);
            if (iREN && iwait === 1'b0) score(1'b0, iload);
        end
    end

    task automatic waitDone(input int target, input string name);
        int n = 0;
        while (nCompleted < target && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check(name, 32'(nCompleted), 32'(target));
    endtask

    task automatic clearStats();
        rdCycles = 0;
        wrCycles = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: actual still running, required finished");
        $fatal(1, "time limit");
    end

    initial begin
        int base;
        int reqCyc;
        int n;

        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;
        ramMem[32'h40]  = 32'h8C220004;
        ramMem[32'h80]  = 32'h33334444;
        ramMem[32'h100] = 32'h11112222;
        ramMem[32'h300] = 32'h55556666;

        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset ramREN", 32'(ramREN), 32'd0);
        check("reset ramWEN", 32'(ramWEN), 32'd0);
        check("reset ramaddr", ramaddr, 32'h0);
        check("reset ramstore", ramstore, 32'h0);
        check("reset iload", iload, 32'h0);
        check("reset dload", dload, 32'h0);
        check("reset memerr", 32'(memerr), 32'd0);
        check("reset iwait", 32'(iwait), 32'd0);
        check("reset dwait", 32'(dwait), 32'd0);
        @(negedge CLK) nRST = 1'b1;
        @(posedge CLK); #1;

        // I-only read, two BUSY cycles before ACCESS
        clearStats(); busyCycles = 2; respErr = 0;
        pushExp(1'b0, 1'b1, 32'h8C220004, 1'b0);
        iaddr = 32'h40; iREN = 1;
        #1 check("iwait while pending", 32'(iwait), 32'd1);
        waitDone(1, "I read completes");
        iREN = 0;
        check("I read ramREN cycles", 32'(rdCycles), 32'd3);
        check("I read ramWEN cycles", 32'(wrCycles), 32'd0);
        check("I read ramaddr", lastAddr, 32'h40);
        check("strobe low after I read", 32'(ramREN), 32'd0);

        // Simultaneous I and D: D served first, I on the next IDLE
        clearStats(); busyCycles = 0;
        base = nCompleted;
        pushExp(1'b1, 1'b1, 32'h11112222, 1'b0);
        pushExp(1'b0, 1'b1, 32'h33334444, 1'b0);
        iaddr = 32'h80; daddr = 32'h100; iREN = 1; dREN = 1;
        waitDone(base + 1, "simultaneous D completes");
        dREN = 0;
        waitDone(base + 2, "simultaneous I completes");
        iREN = 0;
        check("simultaneous last ramaddr", lastAddr, 32'h80);
        check("simultaneous read cycles", 32'(rdCycles), 32'd2);

        // D write with immediate ACCESS, minimum latency
        clearStats(); busyCycles = 0;
        base = nCompleted;
        pushExp(1'b1, 1'b0, 32'h0, 1'b0);
        daddr = 32'h200; dstore = 32'hDEADBEEF; dWEN = 1;
        reqCyc = cyc;
        waitDone(base + 1, "D write completes");
        dWEN = 0;
        check("D write ramWEN cycles", 32'(wrCycles), 32'd1);
        check("D write ramREN cycles", 32'(rdCycles), 32'd0);
        check("D write ramstore", lastStore, 32'hDEADBEEF);
        check("D write ramaddr", lastAddr, 32'h200);
        check("D write latency", 32'(lastDoneCyc - reqCyc), 32'd2);

        // D read back; address changed mid-serve must be ignored
        clearStats(); busyCycles = 1;
        base = nCompleted;
        pushExp(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        daddr = 32'h200; dREN = 1;
        @(posedge CLK); #1;
        daddr = 32'h300;
        waitDone(base + 1, "D readback completes");
        dREN = 0;
        check("D readback ramaddr latched", lastAddr, 32'h200);

        // D read with RAM ERROR
        busyCycles = 1; respErr = 1;
        base = nCompleted;
        pushExp(1'b1, 1'b1, 32'h0, 1'b1);
        daddr = 32'h300; dREN = 1;
        waitDone(base + 1, "D error completes");
        dREN = 0; respErr = 0;

        // Successful I read after the error: memerr stays set
        busyCycles = 0;
        base = nCompleted;
        pushExp(1'b0, 1'b1, 32'h33334444, 1'b1);
        iaddr = 32'h80; iREN = 1;
        waitDone(base + 1, "I read after error completes");
        iREN = 0;

        // Watchdog: RAM stays BUSY, forced error after TIMEOUT serve cycles
        clearStats(); busyCycles = 1000;
        base = nCompleted;
        pushExp(1'b0, 1'b1, 32'h0, 1'b1);
        iaddr = 32'h40; iREN = 1;
        waitDone(base + 1, "I timeout completes");
        iREN = 0;
        check("timeout serve cycles", 32'(rdCycles), 32'd8);

        // Reset during DSERVE
        clearStats(); busyCycles = 1000;
        daddr = 32'h100; dREN = 1;
        n = 0;
        while (rdCycles < 2 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("reset-midserve reached DSERVE", 32'(rdCycles), 32'd2);
        nRST = 1'b0;
        #1;
        check("reset-midserve ramREN", 32'(ramREN), 32'd0);
        check("reset-midserve ramWEN", 32'(ramWEN), 32'd0);
        check("reset-midserve memerr", 32'(memerr), 32'd0);
        check("reset-midserve dwait with request", 32'(dwait), 32'd1);
        dREN = 0; iREN = 0;
        #1;
        check("reset-midserve dwait idle", 32'(dwait), 32'd0);
        check("reset-midserve iwait idle", 32'(iwait), 32'd0);
        @(negedge CLK) nRST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("after reset no new reads", 32'(rdCycles), 32'd2);
        check("after reset ramREN", 32'(ramREN), 32'd0);

        // Both requests held: fairness pattern or strict D priority
        busyCycles = 0;
        base = nCompleted;
`ifdef MEM_ARB_FAIR_EN
        for (int k = 0; k < 2; k++) begin
            pushExp(1'b1, 1'b1, 32'h11112222, 1'b0);
            pushExp(1'b1, 1'b1, 32'h11112222, 1'b0);
            pushExp(1'b0, 1'b1, 32'h33334444, 1'b0);
        end
`else
        for (int k = 0; k < 6; k++) pushExp(1'b1, 1'b1, 32'h11112222, 1'b0);
`endif
        daddr = 32'h100; iaddr = 32'h80; dREN = 1; iREN = 1;
        waitDone(base + 6, "held requests complete six");
`ifndef MEM_ARB_FAIR_EN
        check("I still stalled under D priority", 32'(iwait), 32'd1);
`endif
        dREN = 0; iREN = 0;
        repeat (3) @(posedge CLK);
        #1;
        check("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
